lpc_ring_recorder: RTL and testbench
====================================

Name: lpc_ring_recorder

Overview:
Successor to the single-frame LPC-to-RAM writer. It takes decoded LPC frames over a valid/ready handshake and serialises each one into an 8-byte record. Records go into a parametrised ring of slots in a byte-wide RAM. The block owns the write pointer, compares it against the consumer's read pointer to detect full, drops and counts frames on overflow, and stamps each record with a sequence number, a drop flag and an XOR checksum.

Parameters:
SLOT_BITS, 5, log2 of ring slot count; RAM address width is SLOT_BITS+3.
DROP_W, 8, width of the saturating dropped-frame counter.

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
in_valid  input  1  frame available on in_* this cycle
in_ready  output  1  block accepts a frame at this edge
in_cyctype_dir  input  4  LPC cycle type + direction, LPC spec encoding
in_addr  input  32  LPC address (I/O uses [15:0], upper bits 0)
in_data  input  8  LPC data byte
rd_slot  input  SLOT_BITS  consumer's next slot to read
wr_slot  output  SLOT_BITS  next slot to be written
full  output  1  ring full (combinational)
ram_addr  output  SLOT_BITS+3  {wr_slot, byte_idx}
ram_data  output  8  record byte
ram_we  output  1  write strobe, one per byte
frame_done  output  1  one-cycle pulse after a record is committed
drop_count  output  DROP_W  frames discarded since reset, saturating

Behaviour:
- Reset (async, reset=0): state IDLE; wr_slot=0, byte_idx=0, seq=0, drop_pending=0, drop_count=0; ram_we=0, ram_data=0, frame_done=0. A partially written record is abandoned and its slot reused.
- full = ((wr_slot+1) mod 2^SLOT_BITS == rd_slot). One slot always stays empty. Empty is wr_slot==rd_slot, which is the consumer's concern.
- in_ready = (state==IDLE). Frames are never stalled while IDLE; when full they are accepted and discarded.
- States: IDLE, WRITE.
- IDLE, in_valid=1, full=0 at an edge (accept):
  - Latch all in_* signals and seq.
  - Go to WRITE with byte_idx=0.
  - seq <= seq+1 (8-bit wrap).
  - drop_pending <= 0.
- IDLE, in_valid=1, full=1 at an edge (drop):
  - Stay in IDLE; no RAM write.
  - drop_count <= drop_count+1, held at all-ones.
  - drop_pending <= 1; seq <= seq+1, so the gap is visible in the stored sequence.
- full is evaluated with rd_slot as sampled at the accept edge. A change in rd_slot during WRITE has no effect on the record in progress.
- WRITE: ram_we=1 every cycle; ram_data is registered; byte_idx advances 0..7, one per edge. Record layout:
  - byte0 = {drop_pending_latched, 3'b000, cyctype_dir}
  - byte1..byte4 = addr[31:24], [23:16], [15:8], [7:0]
  - byte5 = data
  - byte6 = seq_latched
  - byte7 = XOR of byte0..byte6
- Latency: accept at edge E0. Bytes 0..7 are on ram_data/ram_addr with ram_we=1 during the cycles after E0..E7. At E8: state IDLE, ram_we=0, wr_slot <= wr_slot+1 (wraps), frame_done=1 for that cycle only.
- in_ready is low from E0 to E8, so the earliest next accept is E9 and the back-to-back period is 9 cycles.
- ram_addr and ram_data hold their last values while ram_we=0; consumers must qualify with ram_we.

Test Plan:
- Single frame: reset, then in_valid with cyctype_dir=4'h2, addr=32'h0000_0080, data=8'hA5 → 8 writes at addresses 0..7 with bytes 02,00,00,00,80,A5,00,27; frame_done pulses once; wr_slot=1.
- Back-to-back: in_valid held high for 3 frames → accepts exactly 9 cycles apart, in_ready low during each WRITE, seq bytes 00,01,02, wr_slot=3.
- Overflow: SLOT_BITS=2, rd_slot=0, send 5 frames → slots 0,1,2 written; 4th and 5th dropped with no ram_we, drop_count=2. Then set rd_slot=2 and send one frame → written to slot 3 with byte0[7]=1 and seq=5.
- Wrap: SLOT_BITS=2, consumer keeps rd_slot trailing, 6 frames → record 5 lands at ram_addr 5'b01_000..01_111; wr_slot wraps 3→0.
- Drop saturation: DROP_W=2, ring full, 6 frames → drop_count sticks at 3.
- Reset mid-record: assert reset at byte_idx=4 → ram_we=0 immediately, wr_slot=0, seq=0; the next frame rewrites slot 0 from byte0.

Source files
------------

// File: rtl/lpc_ring_recorder.sv
// LPC frame recorder: serialises accepted LPC frames into 8-byte records
// in a ring of RAM slots, dropping and counting frames while the ring is full.
module lpc_ring_recorder #(
   parameter int SLOT_BITS = 5,
   parameter int DROP_W    = 8
) (
   input  logic                   clock,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [3:0]             in_cyctype_dir,
   input  logic [31:0]            in_addr,
   input  logic [7:0]             in_data,
   input  logic [SLOT_BITS-1:0]   rd_slot,
   output logic [SLOT_BITS-1:0]   wr_slot,
   output logic                   full,
   output logic [SLOT_BITS+2:0]   ram_addr,
   output logic [7:0]             ram_data,
   output logic                   ram_we,
   output logic                   frame_done,
   output logic [DROP_W-1:0]      drop_count
);

   typedef enum logic {S_IDLE, S_WRITE} state_t;

   state_t               state, state_nxt;
   logic                 accept, drop, last;
   logic [2:0]           byte_idx, byte_nxt;
   logic [7:0]           seq;
   logic                 drop_pending;

   // frame fields captured at the accept edge
   logic [3:0]           cyc_l;
   logic [31:0]          addr_l;
   logic [7:0]           data_l;
   logic [7:0]           seq_l;
   logic                 dp_l;

   logic [7:0]           rec [0:7];
   logic [SLOT_BITS-1:0] wr_slot_inc;

   // one slot is always left empty so full and empty are distinguishable
   assign wr_slot_inc = wr_slot + SLOT_BITS'(1);
   assign full        = (wr_slot_inc == rd_slot);
   assign in_ready    = (state == S_IDLE);
   assign byte_nxt    = byte_idx + 3'd1;

   // record image built from the latched frame; byte 7 closes the XOR checksum
   always_comb begin
      rec[0] = {dp_l, 3'b000, cyc_l};
      rec[1] = addr_l[31:24];
      rec[2] = addr_l[23:16];
      rec[3] = addr_l[15:8];
      rec[4] = addr_l[7:0];
      rec[5] = data_l;
      rec[6] = seq_l;
      rec[7] = rec[0] ^ rec[1] ^ rec[2] ^ rec[3] ^ rec[4] ^ rec[5] ^ rec[6];
   end

   // state register
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // next state and per-edge decisions: accept, drop, or commit the record
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      drop      = 1'b0;
      last      = 1'b0;
      case (state)
         S_IDLE: begin
            if (in_valid) begin
               if (full) begin
                  drop = 1'b1;
               end else begin
                  accept    = 1'b1;
                  state_nxt = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            if (byte_idx == 3'd7) begin
               last      = 1'b1;
               state_nxt = S_IDLE;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   // datapath: byte 0 goes out straight from the inputs at the accept edge,
   // later bytes come from the latched record; RAM outputs hold when idle
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_slot      <= '0;
         byte_idx     <= '0;
         seq          <= '0;
         drop_pending <= 1'b0;
         drop_count   <= '0;
         ram_we       <= 1'b0;
         ram_data     <= '0;
         ram_addr     <= '0;
         frame_done   <= 1'b0;
         cyc_l        <= '0;
         addr_l       <= '0;
         data_l       <= '0;
         seq_l        <= '0;
         dp_l         <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (accept) begin
            cyc_l        <= in_cyctype_dir;
            addr_l       <= in_addr;
            data_l       <= in_data;
            seq_l        <= seq;
            dp_l         <= drop_pending;
            seq          <= seq + 8'd1;
            drop_pending <= 1'b0;
            byte_idx     <= 3'd0;
            ram_we       <= 1'b1;
            ram_addr     <= {wr_slot, 3'd0};
            ram_data     <= {drop_pending, 3'b000, in_cyctype_dir};
         end else if (drop) begin
            if (drop_count != {DROP_W{1'b1}})
               drop_count <= drop_count + DROP_W'(1);
            drop_pending <= 1'b1;
            seq          <= seq + 8'd1;
         end else if (last) begin
            ram_we     <= 1'b0;
            wr_slot    <= wr_slot_inc;
            frame_done <= 1'b1;
            byte_idx   <= 3'd0;
         end else if (state == S_WRITE) begin
            byte_idx <= byte_nxt;
            ram_addr <= {wr_slot, byte_nxt};
            ram_data <= rec[byte_nxt];
         end
      end
   end

endmodule

// File: tb/tb_lpc_ring_recorder.sv
// Self-checking bench for lpc_ring_recorder (4-slot ring, 2-bit drop counter).
module tb_lpc_ring_recorder;

   localparam int SB = 2;
   localparam int DW = 2;
   localparam int NSLOT = 1 << SB;
   localparam int DMAX = (1 << DW) - 1;

   logic            clock = 1'b0;
   logic            reset;
   logic            in_valid;
   logic            in_ready;
   logic [3:0]      in_cyctype_dir;
   logic [31:0]     in_addr;
   logic [7:0]      in_data;
   logic [SB-1:0]   rd_slot;
   logic [SB-1:0]   wr_slot;
   logic            full;
   logic [SB+2:0]   ram_addr;
   logic [7:0]      ram_data;
   logic            ram_we;
   logic            frame_done;
   logic [DW-1:0]   drop_count;

   lpc_ring_recorder #(.SLOT_BITS(SB), .DROP_W(DW)) dut (
      .clock(clock), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_cyctype_dir(in_cyctype_dir), .in_addr(in_addr), .in_data(in_data),
      .rd_slot(rd_slot), .wr_slot(wr_slot), .full(full), .ram_addr(ram_addr),
      .ram_data(ram_data), .ram_we(ram_we), .frame_done(frame_done),
      .drop_count(drop_count)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;
   int cyc_n = 0;
   int fd_cnt = 0;
   int dut_start[$];

   // model: a record in flight is 8 write cycles, then one commit cycle
   int          m_k;      // index of byte expected on the bus, -1 when idle
   int          m_wr;
   int          m_seq;
   bit          m_dp;
   int          m_drop;
   bit          m_fd;
   bit          m_evt;
   logic [7:0]  m_rec [8];
   logic [7:0]  cap [32];

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", nm, act, exp, cyc_n);
      end
   endtask

   task automatic model_reset();
      m_k = -1; m_wr = 0; m_seq = 0; m_dp = 0; m_drop = 0; m_fd = 0; m_evt = 0;
   endtask

   task automatic model_edge();
      m_fd = 0; m_evt = 0;
      if (m_k >= 0) begin
         if (m_k == 7) begin
            m_k = -1; m_wr = (m_wr + 1) % NSLOT; m_fd = 1;
         end else m_k++;
      end else if (in_valid) begin
         m_evt = 1;
         if (((m_wr + 1) % NSLOT) == int'(rd_slot)) begin
            if (m_drop < DMAX) m_drop++;
            m_dp = 1;
            m_seq = (m_seq + 1) % 256;
         end else begin
            m_rec[0] = {m_dp, 3'b000, in_cyctype_dir};
            m_rec[1] = in_addr[31:24];
            m_rec[2] = in_addr[23:16];
            m_rec[3] = in_addr[15:8];
            m_rec[4] = in_addr[7:0];
            m_rec[5] = in_data;
            m_rec[6] = 8'(m_seq);
            m_rec[7] = 8'h00;
            for (int i = 0; i < 7; i++) m_rec[7] = m_rec[7] ^ m_rec[i];
            m_dp = 0;
            m_seq = (m_seq + 1) % 256;
            m_k = 0;
         end
      end
   endtask

   // one clock: advance the model at the edge, compare on the falling edge
   task automatic step();
      @(posedge clock);
      cyc_n++;
      model_edge();
      @(negedge clock);
      chk("in_ready", in_ready, m_k < 0);
      chk("ram_we", ram_we, m_k >= 0);
      chk("frame_done", frame_done, m_fd);
      chk("wr_slot", wr_slot, m_wr);
      chk("drop_count", drop_count, m_drop);
      chk("full", full, ((m_wr + 1) % NSLOT) == int'(rd_slot));
      if (m_k >= 0) begin
         chk("ram_addr", ram_addr, m_wr * 8 + m_k);
         chk("ram_data", ram_data, m_rec[m_k]);
      end
      if (ram_we === 1'b1) begin
         cap[ram_addr] = ram_data;
         if (ram_addr[2:0] == 3'd0) dut_start.push_back(cyc_n);
      end
      if (frame_done === 1'b1) fd_cnt++;
   endtask

   task automatic do_reset();
      reset = 1'b0; in_valid = 1'b0; rd_slot = '0;
      in_cyctype_dir = '0; in_addr = '0; in_data = '0;
      model_reset();
      for (int i = 0; i < 32; i++) cap[i] = 8'h00;
      dut_start.delete();
      fd_cnt = 0;
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic send(input logic [3:0] c, input logic [31:0] a, input logic [7:0] d);
      in_cyctype_dir = c; in_addr = a; in_data = d; in_valid = 1'b1;
      for (int i = 0; i < 30; i++) begin
         step();
         if (m_evt) break;
      end
      if (!m_evt) chk("send_timeout", 0, 1);
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 12 && m_k >= 0; i++) step();
      if (m_k >= 0) chk("drain_timeout", 0, 1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] exp1 [8];
      exp1 = '{8'h02, 8'h00, 8'h00, 8'h00, 8'h80, 8'hA5, 8'h00, 8'h27};

      // reset state
      do_reset();
      chk("rst_ram_we", ram_we, 0);
      chk("rst_ram_data", ram_data, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_in_ready", in_ready, 1);
      chk("rst_wr_slot", wr_slot, 0);
      chk("rst_drop_count", drop_count, 0);
      chk("rst_full", full, 0);

      // single frame with hand-computed record
      send(4'h2, 32'h0000_0080, 8'hA5);
      drain();
      step();
      for (int i = 0; i < 8; i++) chk($sformatf("t1_byte%0d", i), cap[i], exp1[i]);
      chk("t1_wr_slot", wr_slot, 1);
      chk("t1_fd_pulses", fd_cnt, 1);

      // back-to-back with in_valid held high
      do_reset();
      in_cyctype_dir = 4'h3; in_addr = 32'h0000_03F8; in_data = 8'h11; in_valid = 1'b1;
      for (int i = 0; i < 27; i++) step();
      in_valid = 1'b0;
      drain();
      chk("t2_starts", dut_start.size(), 3);
      if (dut_start.size() == 3) begin
         chk("t2_gap0", dut_start[1] - dut_start[0], 9);
         chk("t2_gap1", dut_start[2] - dut_start[1], 9);
      end
      chk("t2_seq0", cap[6], 8'h00);
      chk("t2_seq1", cap[14], 8'h01);
      chk("t2_seq2", cap[22], 8'h02);
      chk("t2_wr_slot", wr_slot, 3);

      // overflow: three written, two dropped, then drop flag and seq gap
      do_reset();
      for (int f = 0; f < 5; f++) begin
         send(4'h0, 32'h0000_0060 + f, 8'(8'h30 + f));
         drain();
      end
      chk("t3_drop_count", drop_count, 2);
      chk("t3_wr_slot", wr_slot, 3);
      rd_slot = 2'd2;
      send(4'h2, 32'h0000_0064, 8'h5A);
      drain();
      step();
      chk("t3_dropflag", cap[24][7], 1'b1);
      chk("t3_seq", cap[30], 8'h05);
      chk("t3_wr_slot_wrap", wr_slot, 0);

      // wrap with the consumer keeping up
      do_reset();
      for (int f = 0; f < 6; f++) begin
         rd_slot = SB'(m_wr);
         send(4'h2, 32'h0000_0100 + f, 8'(f * 17));
         drain();
         if (f == 3) chk("t4_wrap_wr_slot", wr_slot, 0);
      end
      chk("t4_rec5_seq", cap[14], 8'h05);
      chk("t4_rec5_data", cap[13], 8'h55);
      chk("t4_wr_slot", wr_slot, 2);

      // drop counter saturation
      do_reset();
      for (int f = 0; f < 3; f++) begin
         send(4'h2, 32'h0000_0200, 8'(f));
         drain();
      end
      for (int f = 0; f < 6; f++) send(4'h2, 32'h0000_0200, 8'hEE);
      step();
      chk("t5_drop_sat", drop_count, 2'd3);

      // reset in the middle of a record
      do_reset();
      send(4'h2, 32'h0000_0300, 8'h01);
      drain();
      send(4'h3, 32'h0000_0301, 8'h02);
      for (int i = 0; i < 4; i++) step();
      chk("t6_mid_byte", ram_addr[2:0], 3'd4);
      #2;
      reset = 1'b0;
      model_reset();
      #1;
      chk("t6_rst_we", ram_we, 0);
      chk("t6_rst_wr_slot", wr_slot, 0);
      chk("t6_rst_ready", in_ready, 1);
      @(negedge clock);
      reset = 1'b1;
      for (int i = 0; i < 32; i++) cap[i] = 8'h00;
      send(4'h6, 32'h0000_0302, 8'h03);
      drain();
      chk("t6_byte0", cap[0], 8'h06);
      chk("t6_seq", cap[6], 8'h00);
      chk("t6_wr_slot", wr_slot, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
